// File: rtl/bayer_wb_gain.sv
// Black-level subtraction and per-channel white-balance gain for a raw BGBG/GRGR
// Bayer stream, with per-frame channel sums for the AWB loop. Three-cycle pipeline.
module bayer_wb_gain #(
  parameter int GAIN_W = 10,
  parameter int ACC_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [7:0]        bayer_i,
  input  logic              wb_en_i,
  input  logic [7:0]        blc_i,
  input  logic [GAIN_W-1:0] gain_r_i,
  input  logic [GAIN_W-1:0] gain_g_i,
  input  logic [GAIN_W-1:0] gain_b_i,
  output logic              vs_o,
  output logic              hs_o,
  output logic              de_o,
  output logic [7:0]        bayer_o,
  output logic [ACC_W-1:0]  sum_r_o,
  output logic [ACC_W-1:0]  sum_g_o,
  output logic [ACC_W-1:0]  sum_b_o,
  output logic              stat_valid_o
);

  localparam int PW = 8 + GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(256);
  localparam logic [1:0] TAG_B = 2'd0;
  localparam logic [1:0] TAG_G = 2'd1;
  localparam logic [1:0] TAG_R = 2'd2;

  logic              vs_d_q, vs_d_d;
  logic              de_d_q, de_d_d;
  logic              line_par_q, line_par_d;
  logic              pix_par_q, pix_par_d;
  logic [7:0]        blc_sh_q, blc_sh_d;
  logic [GAIN_W-1:0] gain_r_sh_q, gain_r_sh_d;
  logic [GAIN_W-1:0] gain_g_sh_q, gain_g_sh_d;
  logic [GAIN_W-1:0] gain_b_sh_q, gain_b_sh_d;

  // sync bundles are {vs, hs, de}
  logic [2:0]        sync1_q, sync1_d;
  logic [7:0]        d1_q, d1_d;
  logic [1:0]        tag1_q, tag1_d;
  logic [GAIN_W-1:0] gain1_q, gain1_d;
  logic [2:0]        sync2_q, sync2_d;
  logic [PW-1:0]     p2_q, p2_d;
  logic [1:0]        tag2_q, tag2_d;
  logic [2:0]        sync3_q, sync3_d;
  logic [7:0]        bayer_q, bayer_d;
  logic [1:0]        tag3_q, tag3_d;
  logic              vs_o_d_q, vs_o_d_d;
  logic              stat_valid_q, stat_valid_d;

  logic [ACC_W-1:0]  acc_q [0:2];
  logic [ACC_W-1:0]  acc_d [0:2];
  logic [ACC_W-1:0]  sum_q [0:2];
  logic [ACC_W-1:0]  sum_d [0:2];

  logic              vs_rise, de_fall, vs_o_rise;
  logic [PW:0]       rnd;
  logic [PW-8:0]     scaled;

  always_comb begin
    vs_rise   = vs_i & ~vs_d_q;
    de_fall   = de_d_q & ~de_i;
    vs_d_d    = vs_i;
    de_d_d    = de_i;

    line_par_d = line_par_q;
    if (vs_rise)
      line_par_d = 1'b0;
    else if (de_fall)
      line_par_d = ~line_par_q;
    pix_par_d = de_i ? ~pix_par_q : 1'b0;

    blc_sh_d    = blc_sh_q;
    gain_r_sh_d = gain_r_sh_q;
    gain_g_sh_d = gain_g_sh_q;
    gain_b_sh_d = gain_b_sh_q;
    if (vs_rise) begin
      blc_sh_d    = wb_en_i ? blc_i    : 8'd0;
      gain_r_sh_d = wb_en_i ? gain_r_i : UNITY;
      gain_g_sh_d = wb_en_i ? gain_g_i : UNITY;
      gain_b_sh_d = wb_en_i ? gain_b_i : UNITY;
    end

    // Stage 1: black level, channel tag and gain selection from the current phase
    sync1_d = {vs_i, hs_i, de_i};
    d1_d    = (bayer_i > blc_sh_q) ? (bayer_i - blc_sh_q) : 8'd0;
    case ({line_par_q, pix_par_q})
      2'b00:   begin tag1_d = TAG_B; gain1_d = gain_b_sh_q; end
      2'b11:   begin tag1_d = TAG_R; gain1_d = gain_r_sh_q; end
      default: begin tag1_d = TAG_G; gain1_d = gain_g_sh_q; end
    endcase

    // Stage 2: gain multiply
    sync2_d = sync1_q;
    tag2_d  = tag1_q;
    p2_d    = PW'(d1_q) * PW'(gain1_q);

    // Stage 3: round to nearest, clamp; the pixel holds its value outside de
    sync3_d = sync2_q;
    tag3_d  = tag2_q;
    rnd     = {1'b0, p2_q} + (PW+1)'(128);
    scaled  = rnd[PW:8];
    bayer_d = bayer_q;
    if (sync2_q[0])
      bayer_d = (scaled > (PW-7)'(255)) ? 8'hFF : scaled[7:0];

    vs_o_d_d     = sync3_q[2];
    vs_o_rise    = sync3_q[2] & ~vs_o_d_q;
    stat_valid_d = vs_o_rise;
  end

  // One saturating accumulator and report register per channel
  for (genvar gi = 0; gi < 3; gi++) begin : g_acc
    logic           add;
    logic [ACC_W:0] acc_sum;

    always_comb begin
      add      = sync3_q[0] && (tag3_q == 2'(gi));
      acc_sum  = {1'b0, acc_q[gi]} + (ACC_W+1)'(bayer_q);
      acc_d[gi] = acc_q[gi];
      sum_d[gi] = sum_q[gi];
      if (vs_o_rise) begin
        sum_d[gi] = acc_q[gi];
        acc_d[gi] = add ? ACC_W'(bayer_q) : '0;
      end else if (add) begin
        acc_d[gi] = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        acc_q[gi] <= '0;
        sum_q[gi] <= '0;
      end else begin
        acc_q[gi] <= acc_d[gi];
        sum_q[gi] <= sum_d[gi];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_d_q       <= 1'b0;
      de_d_q       <= 1'b0;
      line_par_q   <= 1'b0;
      pix_par_q    <= 1'b0;
      blc_sh_q     <= 8'd0;
      gain_r_sh_q  <= UNITY;
      gain_g_sh_q  <= UNITY;
      gain_b_sh_q  <= UNITY;
      sync1_q      <= 3'b000;
      d1_q         <= 8'd0;
      tag1_q       <= TAG_B;
      gain1_q      <= '0;
      sync2_q      <= 3'b000;
      p2_q         <= '0;
      tag2_q       <= TAG_B;
      sync3_q      <= 3'b000;
      bayer_q      <= 8'd0;
      tag3_q       <= TAG_B;
      vs_o_d_q     <= 1'b0;
      stat_valid_q <= 1'b0;
    end else begin
      vs_d_q       <= vs_d_d;
      de_d_q       <= de_d_d;
      line_par_q   <= line_par_d;
      pix_par_q    <= pix_par_d;
      blc_sh_q     <= blc_sh_d;
      gain_r_sh_q  <= gain_r_sh_d;
      gain_g_sh_q  <= gain_g_sh_d;
      gain_b_sh_q  <= gain_b_sh_d;
      sync1_q      <= sync1_d;
      d1_q         <= d1_d;
      tag1_q       <= tag1_d;
      gain1_q      <= gain1_d;
      sync2_q      <= sync2_d;
      p2_q         <= p2_d;
      tag2_q       <= tag2_d;
      sync3_q      <= sync3_d;
      bayer_q      <= bayer_d;
      tag3_q       <= tag3_d;
      vs_o_d_q     <= vs_o_d_d;
      stat_valid_q <= stat_valid_d;
    end
  end

  assign vs_o         = sync3_q[2];
  assign hs_o         = sync3_q[1];
  assign de_o         = sync3_q[0];
  assign bayer_o      = bayer_q;
  assign sum_b_o      = sum_q[0];
  assign sum_g_o      = sum_q[1];
  assign sum_r_o      = sum_q[2];
  assign stat_valid_o = stat_valid_q;

endmodule

// File: tb/tb_bayer_wb_gain.sv
// Directed bench for bayer_wb_gain: bypass, gain/phase, saturation, shadow
// timing, statistics and mid-frame reset, with hand-computed expectations.
module tb_bayer_wb_gain;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        vs_i, hs_i, de_i;
  logic [7:0]  bayer_i;
  logic        wb_en_i;
  logic [7:0]  blc_i;
  logic [9:0]  gain_r_i, gain_g_i, gain_b_i;
  logic        vs_o, hs_o, de_o;
  logic [7:0]  bayer_o;
  logic [31:0] sum_r_o, sum_g_o, sum_b_o;
  logic        stat_valid_o;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  outq[$];
  logic [2:0]  hist [0:2];
  bit          chk_sync = 1'b0;
  int          pulses = 0;
  logic [31:0] cap_r, cap_g, cap_b;

  bayer_wb_gain #(.GAIN_W(10), .ACC_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i), .bayer_i(bayer_i),
    .wb_en_i(wb_en_i), .blc_i(blc_i),
    .gain_r_i(gain_r_i), .gain_g_i(gain_g_i), .gain_b_i(gain_b_i),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .bayer_o(bayer_o),
    .sum_r_o(sum_r_o), .sum_g_o(sum_g_o), .sum_b_o(sum_b_o),
    .stat_valid_o(stat_valid_o)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one cycle: inputs set before the call appear on the outputs two calls later.
  task automatic step();
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {vs_i, hs_i, de_i};
    @(negedge clock);
    if (de_o) outq.push_back(bayer_o);
    if (stat_valid_o) begin
      pulses++;
      cap_r = sum_r_o;
      cap_g = sum_g_o;
      cap_b = sum_b_o;
    end
    if (chk_sync) check_eq("sync_dly3", 64'({vs_o, hs_o, de_o}), 64'(hist[2]));
  endtask

  // mode 0: ramp row*w+col, mode 1: flat val; gain_g_i jumps to 512 at line chg_line
  task automatic send_frame(input int h, input int w, input int mode, input int val, input int chg_line);
    vs_i = 1'b1; step(); step();
    vs_i = 1'b0; step(); step();
    for (int r = 0; r < h; r++) begin
      if (r == chg_line) gain_g_i = 10'd512;
      hs_i = 1'b1; step();
      hs_i = 1'b0;
      for (int c = 0; c < w; c++) begin
        de_i = 1'b1;
        bayer_i = (mode == 0) ? 8'(r * w + c) : 8'(val);
        step();
      end
      de_i = 1'b0; step(); step();
    end
    repeat (4) step();
  endtask

  task automatic check_frame(input string tag, input int h, input int w,
                             input int eb, input int eg, input int er);
    int exp;
    check_eq({tag, "_len"}, 64'(outq.size()), 64'(h * w));
    for (int i = 0; i < h * w && i < outq.size(); i++) begin
      if ((i / w) % 2 == 0) exp = ((i % w) % 2 == 0) ? eb : eg;
      else                  exp = ((i % w) % 2 == 0) ? eg : er;
      check_eq(tag, 64'(outq[i]), 64'(exp));
    end
    outq.delete();
  endtask

  task automatic set_cfg(input logic en, input int blc, input int gb, input int gg, input int gr);
    wb_en_i = en; blc_i = 8'(blc);
    gain_b_i = 10'(gb); gain_g_i = 10'(gg); gain_r_i = 10'(gr);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_vs"}, 64'(vs_o), 0);
    check_eq({tag, "_hs"}, 64'(hs_o), 0);
    check_eq({tag, "_de"}, 64'(de_o), 0);
    check_eq({tag, "_px"}, 64'(bayer_o), 0);
    check_eq({tag, "_sr"}, 64'(sum_r_o), 0);
    check_eq({tag, "_sg"}, 64'(sum_g_o), 0);
    check_eq({tag, "_sb"}, 64'(sum_b_o), 0);
    check_eq({tag, "_sv"}, 64'(stat_valid_o), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = 3'b000;
    reset_n = 1'b0;
    vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; bayer_i = 8'd0;
    set_cfg(1'b0, 0, 256, 256, 256);
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (2) step();

    // Statistics: first report is empty, second holds frame 1 sums
    pulses = 0;
    send_frame(4, 4, 1, 100, -1);
    check_eq("stat1_pulses", 64'(pulses), 1);
    check_eq("stat1_r", 64'(cap_r), 0);
    check_eq("stat1_g", 64'(cap_g), 0);
    check_eq("stat1_b", 64'(cap_b), 0);
    outq.delete();
    pulses = 0;
    send_frame(4, 4, 1, 100, -1);
    check_eq("stat2_pulses", 64'(pulses), 1);
    check_eq("stat2_r", 64'(cap_r), 400);
    check_eq("stat2_g", 64'(cap_g), 800);
    check_eq("stat2_b", 64'(cap_b), 400);
    repeat (3) step();
    check_eq("stat_hold_b", 64'(sum_b_o), 400);
    check_eq("stat_valid_low", 64'(stat_valid_o), 0);
    outq.delete();

    // Bypass ramp with sync alignment
    set_cfg(1'b0, 40, 900, 700, 100);
    chk_sync = 1'b1;
    send_frame(4, 4, 0, 0, -1);
    chk_sync = 1'b0;
    check_eq("bypass_len", 64'(outq.size()), 16);
    for (int i = 0; i < 16 && i < outq.size(); i++) check_eq("bypass_px", 64'(outq[i]), 64'(i));
    outq.delete();

    // Gain and phase
    set_cfg(1'b1, 0, 512, 256, 128);
    send_frame(4, 4, 1, 100, -1);
    check_frame("gain_phase", 4, 4, 200, 100, 50);

    // Saturation and rounding
    set_cfg(1'b1, 0, 1023, 1023, 1023);
    send_frame(2, 2, 1, 200, -1);
    check_frame("sat_high", 2, 2, 255, 255, 255);
    set_cfg(1'b1, 16, 256, 256, 256);
    send_frame(2, 2, 1, 10, -1);
    check_frame("blc_floor", 2, 2, 0, 0, 0);
    set_cfg(1'b1, 0, 384, 384, 384);
    send_frame(2, 2, 1, 3, -1);
    check_frame("round", 2, 2, 5, 5, 5);

    // Shadow timing: mid-frame gain change only lands on the next frame
    set_cfg(1'b1, 0, 256, 256, 256);
    send_frame(4, 4, 1, 100, 2);
    check_frame("shadow_cur", 4, 4, 100, 100, 100);
    send_frame(4, 4, 1, 100, -1);
    check_frame("shadow_next", 4, 4, 100, 200, 100);

    // Reset in the middle of line 1
    set_cfg(1'b1, 0, 512, 256, 128);
    vs_i = 1'b1; step(); step();
    vs_i = 1'b0; step(); step();
    for (int r = 0; r < 2; r++) begin
      hs_i = 1'b1; step();
      hs_i = 1'b0;
      for (int c = 0; c < ((r == 0) ? 4 : 2); c++) begin
        de_i = 1'b1; bayer_i = 8'd100; step();
      end
      if (r == 0) begin de_i = 1'b0; step(); step(); end
    end
    reset_n = 1'b0;
    de_i = 1'b0;
    #1;
    check_idle_outputs("midrst");
    step(); step();
    check_idle_outputs("midrst_hold");
    reset_n = 1'b1;
    outq.delete();
    // Pixels before the next vs rise run on the reset shadow (unity)
    hs_i = 1'b1; step();
    hs_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      de_i = 1'b1; bayer_i = 8'd100; step();
    end
    de_i = 1'b0;
    repeat (5) step();
    check_frame("post_rst_shadow", 1, 2, 100, 100, 100);
    send_frame(4, 4, 1, 100, -1);
    check_frame("post_rst_phase", 4, 4, 200, 100, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bayer_wb_gain.md
# bayer_wb_gain

Upstream neighbour of the demosaic stage. Applies per-channel black-level subtraction and white-balance gain to a raw 8-bit Bayer stream (BGBG…/GRGR… pattern) and gathers per-frame channel sums for the AWB firmware loop. Output timing and format match the demosaic input, so the block drops in directly ahead of it.

## Interface
Parameters:
- GAIN_W, 10, gain width; unsigned Q2.8 (256 = 1.0, max 1023 ≈ 3.996)
- ACC_W, 32, statistics accumulator width

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- vs_i / hs_i / de_i  in  1 each  input sync and data-enable, active-high
- bayer_i  in  8  raw pixel, valid when de_i=1
- wb_en_i  in  1  1 = apply correction; 0 = bypass (blc 0, gains 256)
- blc_i  in  8  black level, subtracted from every pixel
- gain_r_i / gain_g_i / gain_b_i  in  GAIN_W each  channel gains
- vs_o / hs_o / de_o  out  1 each  syncs delayed 3 cycles
- bayer_o  out  8  corrected pixel
- sum_r_o / sum_g_o / sum_b_o  out  ACC_W each  previous-frame channel sums
- stat_valid_o  out  1  one-cycle pulse when the sums update

## Operation
- Frame start: vs_rise = vs_i & ~vs_d (vs_d = vs_i registered).
- Shadow config: on vs_rise, capture blc_i, gains and wb_en_i into shadow registers. The datapath uses only the shadow values. If wb_en is 0, the captured values are blc = 0 and all gains = 256. Shadow reset: blc 0, gains 256.
- Phase tracking:
  - line_par: cleared on vs_rise; toggled on de falling (de_d & ~de_i).
  - pix_par: cleared on the cycle before each line (~de_i); toggled on each de_i=1 cycle.
  - If vs_rise and de falling occur in the same cycle, the clear wins.
- Channel select, evaluated on the de_i cycle: (line_par, pix_par) = 00 → B, 01 → G, 10 → G, 11 → R.
- Stage 1 (registered): d1 = bayer_i − blc, saturating at 0. Stage 1 also registers the channel tag and the selected gain.
- Stage 2: p2 = d1 × gain (18 bits, unsigned).
- Stage 3: bayer_o = min((p2 + 128) >> 8, 255).
- The sync signals are delayed 3 cycles, aligned with bayer_o. bayer_o is held (not forced to 0) when de_o = 0.
- Statistics:
  - Three ACC_W accumulators add bayer_o on de_o=1 cycles, into the accumulator selected by the stage-3 tag. Both greens go to the G accumulator.
  - Each accumulator saturates at 2^ACC_W − 1.
  - On a rising edge of vs_o: copy the accumulators to sum_*_o, pulse stat_valid_o for 1 cycle, and clear the accumulators. If de_o=1 in that cycle, the accumulator loads the current pixel instead of 0.
  - The first vs_o rise after reset reports zeros.
- Reset mid-frame: all state clears immediately. Output stays idle until the next vs_rise; pixels before it use reset parity and shadow values.

## Timing
- Latency is 3 cycles from bayer_i/de_i to bayer_o/de_o; throughput is 1 pixel per clock with no stalls.
- Reset values:
  - vs_o, hs_o, de_o, stat_valid_o: 0
  - bayer_o: 0
  - sum_r_o, sum_g_o, sum_b_o: 0
  - accumulators, line_par, pix_par, vs_d, de_d: 0
- Config changes take effect only on the pixel stream that follows vs_rise. Changes mid-frame have no effect on the current frame.
- stat_valid_o is asserted on the cycle after the vs_o rising edge. sum_*_o are stable from that cycle until the next pulse.
- de_i may toggle with any gap; parity depends only on de edges, not on hs_i.

## Test plan
- **Bypass:** wb_en_i=0, 4×4 ramp frame with values 0..15 → bayer_o equals bayer_i exactly, 3 cycles later; de_o/hs_o/vs_o equal the inputs delayed 3.
- **Gain and phase:** wb_en_i=1, blc=0, gain_b=512, gain_g=256, gain_r=128, flat frame of 100 → output pattern is B=200, G=100 (line 0) and G=100, R=50 (line 1).
- **Saturation and rounding:**
  - Pixel 200 with gain 1023 → 255.
  - blc=16 with pixel 10 → 0.
  - Pixel 3 with gain 384 → (1152+128)>>8 = 5.
- **Shadow timing:** change gain_g_i from 256 to 512 mid-frame → current frame G stays 100; the next frame's G = 200.
- **Statistics:** two 4×4 flat frames of 100, unity gain → on the second vs_o rise, sum_b=400, sum_g=800, sum_r=400 and stat_valid_o pulses exactly 1 cycle. The first pulse reports 0/0/0.
- **Reset mid-frame:** assert reset_n low for 2 cycles in the middle of line 1 → all outputs 0 immediately. The next frame's phases start at B with shadow gains at 256.
